// File: rtl/ex_div_seq_pkg.sv
// ============================================================================
// Module : ex_div_seq_pkg
// Brief  : Shared widths, FSM encodings and helpers for the Ex divide sequencer
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ex_div_seq_pkg;

    localparam int REG_BUS_W        = 32;
    localparam int DOUBLE_REG_BUS_W = 64;
    localparam int DIV_CNT_W        = 6;

    localparam logic [1:0] DIV_FREE    = 2'b00;
    localparam logic [1:0] DIV_BY_ZERO = 2'b01;
    localparam logic [1:0] DIV_ON      = 2'b10;
    localparam logic [1:0] DIV_END     = 2'b11;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

    localparam logic [DIV_CNT_W-1:0] DIV_STEPS = 6'd32;

    // Magnitude of an operand; raw value when the divide is unsigned.
    function automatic logic [REG_BUS_W-1:0] div_abs(input logic               i_signed,
                                                     input logic [REG_BUS_W-1:0] i_val);
        return (i_signed && i_val[REG_BUS_W-1]) ? (~i_val + 32'd1) : i_val;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ex_div_seq_if.sv
// ============================================================================
// Module : ex_div_seq_if
// Brief  : Ex <-> divide sequencer request/result bundle
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface ex_div_seq_if;
    import ex_div_seq_pkg::*;

    logic                        signed_div_i;
    logic [REG_BUS_W-1:0]        opdata1_i;
    logic [REG_BUS_W-1:0]        opdata2_i;
    logic                        start_i;
    logic                        annul_i;
    logic [DOUBLE_REG_BUS_W-1:0] result_o;
    logic                        ready_o;
    logic                        stallreq_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o, stallreq_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o, stallreq_o
    );

endinterface

`default_nettype wire

// File: rtl/ex_div_seq_div_step.sv
// ============================================================================
// Module : div_step
// Brief  : One combinational restoring-division iteration
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module div_step
    import ex_div_seq_pkg::*;
(
    input  wire logic [REG_BUS_W-1:0] i_rem,
    input  wire logic                 i_qmsb,
    input  wire logic [REG_BUS_W-1:0] i_div,
    output logic      [REG_BUS_W-1:0] o_rem,
    output logic                      o_qbit
);

    logic [REG_BUS_W:0] w_trial;

    // Partial remainder stays below the divisor, so bit 32 is a clean borrow.
    assign w_trial = {i_rem, i_qmsb} - {1'b0, i_div};
    assign o_qbit  = ~w_trial[REG_BUS_W];
    assign o_rem   = o_qbit ? w_trial[REG_BUS_W-1:0] : {i_rem[REG_BUS_W-2:0], i_qmsb};

endmodule

`default_nettype wire

// File: rtl/ex_div_seq.sv
// ============================================================================
// Module : ex_div_seq
// Brief  : 32-step restoring divide sequencer with stall request for Ex
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ex_div_seq
    import ex_div_seq_pkg::*;
(
    input  wire logic    clk,
    input  wire logic    rst,
    ex_div_seq_if.slave  bus
);

    logic [1:0]                  r_state;
    logic [1:0]                  w_state_nxt;
    logic [DIV_CNT_W-1:0]        r_cnt,    w_cnt_nxt;
    logic [REG_BUS_W-1:0]        r_q,      w_q_nxt;
    logic [REG_BUS_W-1:0]        r_rem,    w_rem_nxt;
    logic [REG_BUS_W-1:0]        r_dvs,    w_dvs_nxt;
    logic                        r_neg_q,  w_neg_q_nxt;
    logic                        r_neg_r,  w_neg_r_nxt;
    logic [DOUBLE_REG_BUS_W-1:0] r_result, w_result_nxt;
    logic                        r_ready,  w_ready_nxt;

    logic [REG_BUS_W-1:0]        w_step_rem;
    logic                        w_step_qbit;
    logic                        w_req;

    assign w_req = (bus.start_i == DIV_START) && !bus.annul_i;

    div_step u_step (
        .i_rem  (r_rem),
        .i_qmsb (r_q[REG_BUS_W-1]),
        .i_div  (r_dvs),
        .o_rem  (w_step_rem),
        .o_qbit (w_step_qbit)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= DIV_FREE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            DIV_FREE:    if (w_req) w_state_nxt = (bus.opdata2_i == '0) ? DIV_BY_ZERO : DIV_ON;
            DIV_BY_ZERO: w_state_nxt = bus.annul_i ? DIV_FREE : DIV_END;
            DIV_ON: begin
                if (bus.annul_i)             w_state_nxt = DIV_FREE;
                else if (r_cnt == DIV_STEPS) w_state_nxt = DIV_END;
            end
            DIV_END:     if (bus.start_i == DIV_STOP) w_state_nxt = DIV_FREE;
            default:     w_state_nxt = DIV_FREE;
        endcase
    end

    always_comb begin
        w_cnt_nxt    = r_cnt;
        w_q_nxt      = r_q;
        w_rem_nxt    = r_rem;
        w_dvs_nxt    = r_dvs;
        w_neg_q_nxt  = r_neg_q;
        w_neg_r_nxt  = r_neg_r;
        w_result_nxt = r_result;
        w_ready_nxt  = r_ready;
        case (r_state)
            DIV_FREE: begin
                w_result_nxt = '0;
                w_ready_nxt  = DIV_RESULT_NOT_READY;
                if (w_req && bus.opdata2_i != '0) begin
                    w_q_nxt     = div_abs(bus.signed_div_i, bus.opdata1_i);
                    w_dvs_nxt   = div_abs(bus.signed_div_i, bus.opdata2_i);
                    w_rem_nxt   = '0;
                    w_cnt_nxt   = '0;
                    // Signs are captured here so the correction does not depend on Ex holding operands.
                    w_neg_q_nxt = bus.signed_div_i && (bus.opdata1_i[REG_BUS_W-1] ^ bus.opdata2_i[REG_BUS_W-1]);
                    w_neg_r_nxt = bus.signed_div_i && bus.opdata1_i[REG_BUS_W-1];
                end
            end
            DIV_BY_ZERO: begin
                w_result_nxt = '0;
                w_ready_nxt  = bus.annul_i ? DIV_RESULT_NOT_READY : DIV_RESULT_READY;
            end
            DIV_ON: begin
                if (bus.annul_i) begin
                    w_ready_nxt = DIV_RESULT_NOT_READY;
                end else if (r_cnt != DIV_STEPS) begin
                    w_rem_nxt = w_step_rem;
                    w_q_nxt   = {r_q[REG_BUS_W-2:0], w_step_qbit};
                    w_cnt_nxt = r_cnt + 6'd1;
                end else begin
                    w_result_nxt = {r_neg_r ? (~r_rem + 32'd1) : r_rem,
                                    r_neg_q ? (~r_q + 32'd1) : r_q};
                    w_ready_nxt  = DIV_RESULT_READY;
                end
            end
            DIV_END: begin
                if (bus.start_i == DIV_STOP) begin
                    w_result_nxt = '0;
                    w_ready_nxt  = DIV_RESULT_NOT_READY;
                end
            end
            default: begin
                w_result_nxt = '0;
                w_ready_nxt  = DIV_RESULT_NOT_READY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_q      <= '0;
            r_rem    <= '0;
            r_dvs    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
            r_ready  <= DIV_RESULT_NOT_READY;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_q      <= w_q_nxt;
            r_rem    <= w_rem_nxt;
            r_dvs    <= w_dvs_nxt;
            r_neg_q  <= w_neg_q_nxt;
            r_neg_r  <= w_neg_r_nxt;
            r_result <= w_result_nxt;
            r_ready  <= w_ready_nxt;
        end
    end

    assign bus.result_o   = r_result;
    assign bus.ready_o    = r_ready;
    assign bus.stallreq_o = bus.start_i & ~r_ready;

endmodule

`default_nettype wire

// File: tb/tb_ex_div_seq.sv
// ============================================================================
// Module : tb_ex_div_seq
// Brief  : Directed self-checking bench for the Ex divide sequencer
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ex_div_seq;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    ex_div_seq_if bus ();

    ex_div_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Issues a divide and waits (bounded) for ready; edges counts from the sampling edge.
    task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          output int edges, output logic [63:0] res, output logic stall_ok);
        bus.signed_div_i = sgn;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.start_i      = 1'b1;
        stall_ok         = 1'b1;
        edges            = 0;
        #1;
        if (bus.stallreq_o !== 1'b1) stall_ok = 1'b0;
        while (edges < 40) begin
            @(posedge clk); #1;
            edges++;
            if (bus.ready_o === 1'b1) break;
            if (bus.stallreq_o !== 1'b1) stall_ok = 1'b0;
        end
        res = bus.result_o;
    endtask

    task automatic drop_start();
        bus.start_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i = '0;
        bus.opdata2_i = '0;
        bus.start_i = 1'b0;
        bus.annul_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        n_cmp++; if (bus.ready_o !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", bus.ready_o); end
        n_cmp++; if (bus.result_o !== 64'h0) begin n_bad++; $display("FAIL reset_result: got %h want 0", bus.result_o); end
        n_cmp++; if (bus.stallreq_o !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", bus.stallreq_o); end
    endtask

    task automatic test_unsigned();
        int e; logic [63:0] r; logic s;
        do_div(1'b0, 32'd100, 32'd7, e, r, s);
        n_cmp++; if (e !== 34) begin n_bad++; $display("FAIL udiv_latency: got %0d want 34", e); end
        n_cmp++; if (r !== 64'h00000002_0000000E) begin n_bad++; $display("FAIL udiv_result: got %h want 000000020000000e", r); end
        n_cmp++; if (s !== 1'b1) begin n_bad++; $display("FAIL udiv_stall_inflight: got %b want 1", s); end
        n_cmp++; if (bus.stallreq_o !== 1'b0) begin n_bad++; $display("FAIL udiv_stall_done: got %b want 0", bus.stallreq_o); end
        @(posedge clk); #1;
        n_cmp++; if (bus.ready_o !== 1'b1 || bus.result_o !== 64'h00000002_0000000E) begin
            n_bad++; $display("FAIL udiv_hold: got ready=%b res=%h want ready=1 res=000000020000000e", bus.ready_o, bus.result_o);
        end
        drop_start();
        n_cmp++; if (bus.ready_o !== 1'b0 || bus.result_o !== 64'h0) begin
            n_bad++; $display("FAIL udiv_release: got ready=%b res=%h want 0/0", bus.ready_o, bus.result_o);
        end
        n_cmp++; if (dut.r_state !== 2'b00) begin n_bad++; $display("FAIL udiv_free: got state %b want 00", dut.r_state); end
    endtask

    task automatic test_signed();
        int e; logic [63:0] r; logic s;
        do_div(1'b1, 32'hFFFF_FFF9, 32'h2, e, r, s);
        n_cmp++; if (r !== 64'hFFFFFFFF_FFFFFFFD) begin n_bad++; $display("FAIL sdiv_neg7_2: got %h want fffffffffffffffd", r); end
        n_cmp++; if (e !== 34) begin n_bad++; $display("FAIL sdiv_latency: got %0d want 34", e); end
        drop_start();
        do_div(1'b1, 32'd7, 32'hFFFF_FFFE, e, r, s);
        n_cmp++; if (r !== 64'h00000001_FFFFFFFD) begin n_bad++; $display("FAIL sdiv_7_neg2: got %h want 00000001fffffffd", r); end
        drop_start();
    endtask

    task automatic test_div_zero();
        int e; logic [63:0] r; logic s;
        do_div(1'b0, 32'd5, 32'd0, e, r, s);
        n_cmp++; if (e !== 2) begin n_bad++; $display("FAIL udiv0_latency: got %0d want 2", e); end
        n_cmp++; if (r !== 64'h0) begin n_bad++; $display("FAIL udiv0_result: got %h want 0", r); end
        drop_start();
        n_cmp++; if (bus.ready_o !== 1'b0) begin n_bad++; $display("FAIL udiv0_release: got %b want 0", bus.ready_o); end
        do_div(1'b1, 32'd5, 32'd0, e, r, s);
        n_cmp++; if (e !== 2 || r !== 64'h0) begin n_bad++; $display("FAIL sdiv0: got edges=%0d res=%h want 2/0", e, r); end
        drop_start();
        n_cmp++; if (bus.ready_o !== 1'b0) begin n_bad++; $display("FAIL sdiv0_release: got %b want 0", bus.ready_o); end
    endtask

    task automatic test_boundary();
        int e; logic [63:0] r; logic s;
        do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, e, r, s);
        n_cmp++; if (r !== 64'h00000000_80000000) begin n_bad++; $display("FAIL sdiv_min_neg1: got %h want 0000000080000000", r); end
        drop_start();
        do_div(1'b0, 32'hFFFF_FFFF, 32'd1, e, r, s);
        n_cmp++; if (r !== 64'h00000000_FFFFFFFF) begin n_bad++; $display("FAIL udiv_max_1: got %h want 00000000ffffffff", r); end
        drop_start();
    endtask

    task automatic test_annul();
        int e; logic [63:0] r; logic s;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i = 32'd100;
        bus.opdata2_i = 32'd7;
        bus.start_i = 1'b1;
        repeat (11) begin @(posedge clk); #1; end
        n_cmp++; if (dut.r_cnt !== 6'd10 || bus.ready_o !== 1'b0) begin
            n_bad++; $display("FAIL annul_pre: got cnt=%0d ready=%b want 10/0", dut.r_cnt, bus.ready_o);
        end
        bus.annul_i = 1'b1;
        @(posedge clk); #1;
        bus.annul_i = 1'b0;
        n_cmp++; if (dut.r_state !== 2'b00 || bus.ready_o !== 1'b0) begin
            n_bad++; $display("FAIL annul_free: got state=%b ready=%b want 00/0", dut.r_state, bus.ready_o);
        end
        do_div(1'b0, 32'd9, 32'd3, e, r, s);
        n_cmp++; if (e !== 34 || r !== 64'h00000000_00000003) begin
            n_bad++; $display("FAIL annul_restart: got edges=%0d res=%h want 34/0000000000000003", e, r);
        end
        drop_start();
    endtask

    task automatic test_rst_mid();
        int e; logic [63:0] r; logic s;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i = 32'd100;
        bus.opdata2_i = 32'd7;
        bus.start_i = 1'b1;
        repeat (21) begin @(posedge clk); #1; end
        n_cmp++; if (dut.r_cnt !== 6'd20) begin n_bad++; $display("FAIL rst_mid_cnt: got %0d want 20", dut.r_cnt); end
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (dut.r_state !== 2'b00 || bus.ready_o !== 1'b0 || bus.result_o !== 64'h0) begin
            n_bad++; $display("FAIL rst_mid_state: got state=%b ready=%b res=%h want 00/0/0", dut.r_state, bus.ready_o, bus.result_o);
        end
        n_cmp++; if (bus.stallreq_o !== 1'b1) begin n_bad++; $display("FAIL rst_mid_stall: got %b want 1", bus.stallreq_o); end
        rst = 1'b0;
        do_div(1'b0, 32'd100, 32'd7, e, r, s);
        n_cmp++; if (e !== 34 || r !== 64'h00000002_0000000E) begin
            n_bad++; $display("FAIL rst_mid_recover: got edges=%0d res=%h want 34/000000020000000e", e, r);
        end
        drop_start();
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_boundary();
        test_annul();
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ex_div_seq.md
# ex_div_seq

Multi-cycle divide sequencer beside the Ex stage. Ex issues a 32-bit signed or unsigned divide with a start level. The block runs a 32-step restoring division and returns a 64-bit {remainder, quotient} result with a ready flag. While the divide is in flight it raises a stall request so the pipeline holds the instruction in Ex.

## Interface
Parameters: none. Widths are fixed: RegBus is 32 bits, DoubleRegBus is 64 bits.

- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- signed_div_i  in  1  1 = signed divide, 0 = unsigned
- opdata1_i  in  32  dividend
- opdata2_i  in  32  divisor
- start_i  in  1  divide request, level; held high by Ex until ready_o is seen
- annul_i  in  1  flush; cancels an in-flight divide
- result_o  out  64  [63:32] remainder (HI), [31:0] quotient (LO); registered
- ready_o  out  1  result valid; registered
- stallreq_o  out  1  combinational: start_i & ~ready_o

## Operation
- States (2-bit): FREE, BYZERO, ON, END. Reset puts the block in FREE with result_o = 0, ready_o = 0, cnt = 0.
- Operands are sampled only in FREE and must be held stable by Ex until ready_o.

FREE
- If start_i & ~annul_i and opdata2_i == 0: go to BYZERO.
- If start_i & ~annul_i and opdata2_i != 0: go to ON. Load |dividend| and |divisor| (absolute values only when signed_div_i = 1; raw values otherwise). Clear the partial remainder. cnt = 0.
- Otherwise: stay; ready_o = 0, result_o = 0.

BYZERO
- annul_i: go to FREE.
- Otherwise: result_o = 0, ready_o = 1, go to END.

ON
- annul_i has priority: go to FREE, ready_o stays 0, partial state is discarded.
- If cnt != 32, one restoring step:
  - T = {R[31:0], Qmsb} - {1'b0, D}, computed in 33 bits.
  - If there is no borrow: R = T[31:0] and shift 1 into Q.
  - If there is a borrow: R = {R[30:0], Qmsb} and shift 0 into Q.
  - cnt++.
- If cnt == 32: apply sign correction, write result_o, set ready_o = 1, go to END.
  - Quotient is negated when signed_div_i = 1 and the operand signs differ.
  - Remainder is negated when signed_div_i = 1 and the dividend is negative.

END
- Hold result_o and ready_o = 1 while start_i is high.
- When start_i is low: go to FREE, ready_o = 0, result_o = 0.
- annul_i is ignored in END.

Arithmetic rules
- All arithmetic is modulo 2^32.
- Signed 0x8000_0000 / 0xFFFF_FFFF gives quotient 0x8000_0000, remainder 0 (no trap).
- Divide-by-zero gives result 0, signed or unsigned.

Boundary conditions
- rst has priority over every input in every state and returns the block to FREE within one edge.
- start_i re-asserted in the same cycle the block returns to FREE is sampled on the following edge.

## Timing
- Nonzero divisor: start_i sampled at edge N; steps run at edges N+1 to N+32; ready_o and result_o are valid after edge N+33. stallreq_o is high for 33 cycles plus the request cycle.
- Divisor zero: ready_o is valid after edge N+1.
- After ready_o, Ex drops start_i at the next edge; the block is back in FREE one edge later, so back-to-back divides have a 1-cycle gap.
- Annul in ON or BYZERO: FREE after the same edge; ready_o never pulses.

## Structure
- Add to Defines.v:
  - DivFree / DivByZero / DivOn / DivEnd (2'b00..2'b11)
  - DivResultReady / DivResultNotReady
  - DivStart / DivStop
  - DoubleRegBus 63:0
  - DivCntBus 5:0
- Sub-module: div_step, purely combinational. One restoring iteration: inputs R, Qmsb, D; outputs R', qbit. Instantiated once in ex_div_seq.
- Ex drives opdata and start_i, muxes result_o into HI/LO write data, and ORs stallreq_o into its stall request.

## Test plan
- Unsigned 100 / 7, start held → ready_o after edge N+33, result_o = 0x00000002_0000000E; stallreq_o low from then on.
- Signed -7 / 2 (0xFFFF_FFF9, 0x2) → quotient 0xFFFF_FFFD, remainder 0xFFFF_FFFF. Signed 7 / -2 → quotient 0xFFFF_FFFD, remainder 0x0000_0001.
- 5 / 0, unsigned and signed → ready_o after edge N+1, result_o = 0; then start_i low → FREE, ready_o = 0.
- Signed 0x8000_0000 / 0xFFFF_FFFF → result_o = 0x00000000_80000000. Unsigned 0xFFFF_FFFF / 1 → 0x00000000_FFFFFFFF.
- annul_i pulsed at step 10 → FREE next edge, ready_o never asserts. An immediate new start (9 / 3) returns 0x00000000_00000003 with full 33-edge latency.
- rst asserted mid-ON (cnt = 20) → after that edge: state FREE, ready_o = 0, result_o = 0, stallreq_o = start_i.
